// File: rtl/regfile_sb_pkg.sv
// Shared constants for the scoreboarded register file.
// Configuration macro: REGFILE_SB_BYPASS_EN (writeback-to-read forwarding).
package riscv_rf_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    function automatic int aw_of(input int nreg);
        return $clog2(nreg);
    endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard with flush, issue/writeback priority and live count.
// Priority per edge: flush > issue set > writeback clear.
module regfile_scoreboard
    import riscv_rf_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    localparam int AW = aw_of(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic            flush,
    output logic [NREG-1:0] busy,
    output logic [AW:0]     busy_cnt
);

    logic [NREG-1:0] busy_nxt;
    logic [AW:0]     cnt_nxt;

    always_comb begin
        busy_nxt = busy;
        if (wb_valid) busy_nxt[wb_rd] = 1'b0;
        if (iss_valid) busy_nxt[iss_rd] = 1'b1;
        if (flush) busy_nxt = '0;
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with combinational read ports and a busy-bit scoreboard.
// Define REGFILE_SB_BYPASS_EN to forward writeback data to same-cycle reads.
module regfile_sb
    import riscv_rf_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRP  = 2,
    localparam int AW  = aw_of(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRP*AW-1:0]   rd_addr_i,
    output logic [NRP*XLEN-1:0] rd_data_o,
    output logic [NRP-1:0]      rd_busy_o,
    input  logic                iss_valid_i,
    input  logic [AW-1:0]       iss_rd_i,
    input  logic                wb_valid_i,
    input  logic [AW-1:0]       wb_rd_i,
    input  logic [XLEN-1:0]     wb_data_i,
    input  logic                flush_i,
    output logic [AW:0]         busy_cnt_o
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic            wb_en;
    logic            iss_en;

    assign wb_en  = wb_valid_i && (wb_rd_i != '0);
    assign iss_en = iss_valid_i && (iss_rd_i != '0);

    // regs[0] is never written, so it holds its reset value of zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[wb_rd_i] <= wb_data_i;
        end
    end

    regfile_scoreboard #(
        .NREG (NREG)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_en),
        .iss_rd    (iss_rd_i),
        .wb_valid  (wb_en),
        .wb_rd     (wb_rd_i),
        .flush     (flush_i),
        .busy      (busy),
        .busy_cnt  (busy_cnt_o)
    );

    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rd_addr_i[p*AW +: AW];
`ifdef REGFILE_SB_BYPASS_EN
        logic fwd;
        assign fwd = wb_en && (wb_rd_i == addr);
        assign rd_data_o[p*XLEN +: XLEN] = fwd ? wb_data_i : regs[addr];
        assign rd_busy_o[p] = fwd ? 1'b0 : busy[addr];
`else
        assign rd_data_o[p*XLEN +: XLEN] = regs[addr];
        assign rd_busy_o[p] = busy[addr];
`endif
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, register data width in bits.
REQ-002 Parameter NREG, default 32, number of architectural registers (power of two, 2..64); AW = log2(NREG).
REQ-003 Parameter NRP, default 2, number of read ports (1..4).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 rd_addr_i  input  NRP*AW  read addresses; port p occupies bits [p*AW +: AW].
REQ-007 rd_data_o  output  NRP*XLEN  read data; port p occupies bits [p*XLEN +: XLEN].
REQ-008 rd_busy_o  output  NRP  per-port flag: operand has a pending producer, so the data is stale.
REQ-009 iss_valid_i  input  1  issue strobe: an instruction writing iss_rd_i has been dispatched.
REQ-010 iss_rd_i  input  AW  destination register of the issued instruction.
REQ-011 wb_valid_i  input  1  writeback strobe.
REQ-012 wb_rd_i  input  AW  writeback destination register.
REQ-013 wb_data_i  input  XLEN  writeback data.
REQ-014 flush_i  input  1  pipeline flush; clears all pending producers.
REQ-015 busy_cnt_o  output  AW+1  number of registers currently marked busy.

Function
REQ-016 Register 0 SHALL always read 0 and never be marked busy; writes and issues to register 0 SHALL be ignored.
REQ-017 Reads SHALL be combinational: rd_data_o for port p = regs[rd_addr_i[p]], with zero-cycle latency.
REQ-018 Write: on a clock edge with wb_valid_i=1 and wb_rd_i!=0, regs[wb_rd_i] SHALL take wb_data_i.
REQ-019 Scoreboard: busy[iss_rd_i] SHALL be set on an edge with iss_valid_i=1 and iss_rd_i!=0.
REQ-020 busy[wb_rd_i] SHALL be cleared on an edge with wb_valid_i=1 and wb_rd_i!=0.
REQ-021 Issue and writeback to the same register in the same cycle: set SHALL win (the new producer supersedes the old one); the data write still occurs.
REQ-022 Issue to an already-busy register SHALL leave it busy (WAW tolerated; no error); busy_cnt_o unchanged.
REQ-023 rd_busy_o[p] SHALL equal busy[rd_addr_i[p]] (registered scoreboard state), except as modified by REQ-030.
REQ-024 flush_i=1 SHALL clear every busy bit on that edge, overriding a simultaneous issue; a simultaneous writeback still writes data.
REQ-025 busy_cnt_o SHALL be a registered population count of busy bits, updated in the same edge as the busy bits, never exceeding NREG-1.

Reset
REQ-026 rst_n low SHALL immediately clear all registers to 0, all busy bits, and busy_cnt_o to 0, regardless of clk.
REQ-027 Reset asserted mid-operation SHALL discard any pending issue or writeback in that cycle.
REQ-028 After reset release, the first rising edge SHALL be a normal functional edge.

Configuration
REQ-029 Macro REGFILE_SB_BYPASS_EN selects writeback-to-read forwarding.
REQ-030 With REGFILE_SB_BYPASS_EN defined: if wb_valid_i=1, wb_rd_i!=0 and wb_rd_i==rd_addr_i[p], then rd_data_o[p]=wb_data_i and rd_busy_o[p]=0 in the same cycle.
REQ-031 Without REGFILE_SB_BYPASS_EN: rd_data_o and rd_busy_o SHALL reflect only registered state; written data is visible from the cycle after the write edge.

Structure
REQ-032 Package riscv_rf_pkg SHALL hold the default XLEN/NREG constants and a function returning AW from NREG.
REQ-033 Scoreboard (busy bits, set/clear/flush priority, busy_cnt_o) SHALL be the sub-module regfile_scoreboard; the data array and read muxes stay in regfile_sb.

Verification
REQ-034 Reset, then read all addresses on both ports -> data 0, rd_busy_o=0, busy_cnt_o=0.
REQ-035 Write x5=0xDEADBEEF, then read x5 next cycle -> 0xDEADBEEF; write x0=0x1234 -> x0 reads 0.
REQ-036 Issue x7, then read x7 -> rd_busy_o=1, busy_cnt_o=1; writeback x7=0x55 -> busy clears, count 0, data 0x55.
REQ-037 Same-cycle issue x3 and writeback x3=0xA -> x3 busy=1, data 0xA; flush the next cycle together with an issue of x4 -> all busy clear, count 0.
REQ-038 With REGFILE_SB_BYPASS_EN: x9 busy, writeback x9=0x77 while port 1 reads x9 -> same cycle rd_data_o[1]=0x77, rd_busy_o[1]=0; without the macro -> old data, busy=1.
REQ-039 Assert rst_n low between clock edges while x2..x6 are busy -> outputs zero immediately, count 0.
